// File: rtl/src_reg_sel.sv
// src_reg_sel: read-side pointer and output stage for the three-slot register bank.
//
// Slots are consumed in the ring order 2 -> 0 -> 1 -> 2, which matches the order the write
// side fills them. An occupancy counter stops reads from overtaking writes. A granted read
// loads the selected slot into a registered DOUT and pulses DV for one cycle.
//
// Ports:
//   CLK          system clock; all state updates on the rising edge
//   RST          synchronous active-low reset
//   WR           one-cycle pulse: write side stored a slot this cycle
//   RD           read request level; only its rising edge requests a read
//   R0, R1, R2   slot contents (W bits each)
//   T0, T1, T2   one-hot read pointer
//   DOUT         registered read data
//   DV           DOUT valid, one-cycle pulse
//   EMPTY, FULL  occupancy == 0 / occupancy == 3
//   UFL, OVF     sticky underflow / overflow flags, cleared only by reset
module src_reg_sel #(
    parameter int unsigned W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         WR,
    input  logic         RD,
    input  logic [W-1:0] R0,
    input  logic [W-1:0] R1,
    input  logic [W-1:0] R2,
    output logic         T0,
    output logic         T1,
    output logic         T2,
    output logic [W-1:0] DOUT,
    output logic         DV,
    output logic         EMPTY,
    output logic         FULL,
    output logic         UFL,
    output logic         OVF
);

    // Pointer bit order is {T2, T1, T0}.
    logic [2:0]   ptr_q, ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         rd_q;
    logic [W-1:0] dout_q, dout_d;
    logic         dv_q, dv_d;
    logic         empty_q, empty_d;
    logic         full_q, full_d;
    logic         ufl_q, ufl_d;
    logic         ovf_q, ovf_d;

    logic req;
    logic gnt;
    logic wr_ok;

    always_comb begin
        req   = RD & ~rd_q;
        // The grant uses the registered occupancy, so a same-cycle WR cannot rescue an empty read.
        gnt   = req & ~empty_q;
        wr_ok = WR & ~full_q;

        ptr_d   = ptr_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        cnt_d   = cnt_q;
        ufl_d   = ufl_q | (req & empty_q);
        // A WR while full is absorbed when a read frees a slot in the same cycle.
        ovf_d   = ovf_q | (WR & full_q & ~gnt);

        if (gnt) begin
            unique case (ptr_q)
                3'b100:  dout_d = R2;
                3'b001:  dout_d = R0;
                3'b010:  dout_d = R1;
                default: dout_d = dout_q;
            endcase
            dv_d  = 1'b1;
            // T2 -> T0 -> T1 -> T2
            ptr_d = {ptr_q[1], ptr_q[0], ptr_q[2]};
        end

        // A granted read plus any WR leaves the count unchanged: the accepted write covers
        // the read, and a WR while full takes the slot the read just freed.
        if (gnt && !WR) begin
            cnt_d = cnt_q - 2'd1;
        end else if (!gnt && wr_ok) begin
            cnt_d = cnt_q + 2'd1;
        end

        empty_d = (cnt_d == 2'd0);
        full_d  = (cnt_d == 2'd3);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ptr_q   <= 3'b100;
            cnt_q   <= 2'd0;
            // Reset high so an RD held through reset is not seen as a rising edge.
            rd_q    <= 1'b1;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ufl_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rd_q    <= RD;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ufl_q   <= ufl_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        T2    = ptr_q[2];
        T1    = ptr_q[1];
        T0    = ptr_q[0];
        DOUT  = dout_q;
        DV    = dv_q;
        EMPTY = empty_q;
        FULL  = full_q;
        UFL   = ufl_q;
        OVF   = ovf_q;
    end

endmodule

// File: tb/tb_src_reg_sel.sv
// Table-driven bench for src_reg_sel with a few hand-written multi-cycle sequences.
module tb_src_reg_sel;

    logic       clk;
    logic       rst;
    logic       wr;
    logic       rd;
    logic [3:0] r0, r1, r2;
    logic       t0, t1, t2;
    logic [3:0] dout;
    logic       dv, empty, full, ufl, ovf;

    int checks;
    int errors;

    src_reg_sel #(.W(4)) dut (
        .CLK   (clk),
        .RST   (rst),
        .WR    (wr),
        .RD    (rd),
        .R0    (r0),
        .R1    (r1),
        .R2    (r2),
        .T0    (t0),
        .T1    (t1),
        .T2    (t2),
        .DOUT  (dout),
        .DV    (dv),
        .EMPTY (empty),
        .FULL  (full),
        .UFL   (ufl),
        .OVF   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr;
        logic       rd;
        logic [3:0] r0;
        logic [3:0] r1;
        logic [3:0] r2;
        logic [2:0] ptr;
        logic [3:0] dout;
        logic       dv;
        logic       empty;
        logic       full;
        logic       ufl;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic a_rst, logic a_wr, logic a_rd,
                                logic [3:0] a_r0, logic [3:0] a_r1, logic [3:0] a_r2,
                                logic [2:0] e_ptr, logic [3:0] e_dout, logic e_dv,
                                logic e_empty, logic e_full, logic e_ufl, logic e_ovf);
        vec_t v;
        v.rst = a_rst; v.wr = a_wr; v.rd = a_rd;
        v.r0 = a_r0; v.r1 = a_r1; v.r2 = a_r2;
        v.ptr = e_ptr; v.dout = e_dout; v.dv = e_dv;
        v.empty = e_empty; v.full = e_full; v.ufl = e_ufl; v.ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dv_count;
        checks = 0;
        errors = 0;
        rst = 1'b0; wr = 1'b0; rd = 1'b1;
        r0 = 4'hB; r1 = 4'hC; r2 = 4'hA;

        //            rst wr rd  r0    r1    r2     ptr     dout  dv e  f  u  o
        // Reset held with RD high, then release: RD still high gives no request.
        vecs.push_back(mk(0, 0, 1, 4'hB, 4'hC, 4'hA, 3'b100, 4'h0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'hB, 4'hC, 4'hA, 3'b100, 4'h0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 4'hB, 4'hC, 4'hA, 3'b100, 4'h0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 4'hB, 4'hC, 4'hA, 3'b100, 4'h0, 0, 1, 0, 0, 0));
        // Fill three slots.
        vecs.push_back(mk(1, 1, 0, 4'hB, 4'hC, 4'hA, 3'b100, 4'h0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 4'hB, 4'hC, 4'hA, 3'b100, 4'h0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 4'hB, 4'hC, 4'hA, 3'b100, 4'h0, 0, 0, 1, 0, 0));
        // Drain: A, B, C in ring order.
        vecs.push_back(mk(1, 0, 1, 4'hB, 4'hC, 4'hA, 3'b001, 4'hA, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'hB, 4'hC, 4'hA, 3'b001, 4'hA, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 4'hB, 4'hC, 4'hA, 3'b010, 4'hB, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'hB, 4'hC, 4'hA, 3'b010, 4'hB, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 4'hB, 4'hC, 4'hA, 3'b100, 4'hC, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'hB, 4'hC, 4'hA, 3'b100, 4'hC, 0, 1, 0, 0, 0));
        // Underflow, sticky; then read edge with same-cycle WR still underflows.
        vecs.push_back(mk(1, 0, 1, 4'hB, 4'hC, 4'hA, 3'b100, 4'hC, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 4'hB, 4'hC, 4'hA, 3'b100, 4'hC, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 4'hB, 4'hC, 4'hA, 3'b100, 4'hC, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 4'hB, 4'hC, 4'hA, 3'b100, 4'hC, 0, 0, 0, 1, 0));
        // CNT=1: WR plus read edge reads the old slot, count stays 1.
        vecs.push_back(mk(1, 1, 1, 4'hB, 4'hC, 4'h5, 3'b001, 4'h5, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 4'hB, 4'hC, 4'h5, 3'b001, 4'h5, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 4'hB, 4'hC, 4'h5, 3'b001, 4'h5, 0, 0, 1, 1, 0));
        // Full: WR plus granted read keeps FULL, no overflow.
        vecs.push_back(mk(1, 1, 1, 4'hB, 4'hC, 4'h5, 3'b010, 4'hB, 1, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 4'hB, 4'hC, 4'h5, 3'b010, 4'hB, 0, 0, 1, 1, 0));
        // Full: WR alone overflows, sticky.
        vecs.push_back(mk(1, 1, 0, 4'hB, 4'hC, 4'h5, 3'b010, 4'hB, 0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 4'hB, 4'hC, 4'h5, 3'b010, 4'hB, 0, 0, 1, 1, 1));
        // Bring count to 2, then reset coincident with a read edge.
        vecs.push_back(mk(1, 0, 1, 4'hB, 4'hC, 4'h5, 3'b100, 4'hC, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 4'hB, 4'hC, 4'h5, 3'b100, 4'hC, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 4'hB, 4'hC, 4'h5, 3'b100, 4'h0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 4'hB, 4'hC, 4'h5, 3'b100, 4'h0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'hB, 4'hC, 4'h5, 3'b100, 4'h0, 0, 1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; wr = vecs[i].wr; rd = vecs[i].rd;
            r0 = vecs[i].r0; r1 = vecs[i].r1; r2 = vecs[i].r2;
            step();
            chk($sformatf("vec%0d {ptr,dout,dv,empty,full,ufl,ovf}", i),
                {19'd0, t2, t1, t0, dout, dv, empty, full, ufl, ovf},
                {19'd0, vecs[i].ptr, vecs[i].dout, vecs[i].dv, vecs[i].empty,
                 vecs[i].full, vecs[i].ufl, vecs[i].ovf});
        end

        // RD held high for several cycles yields exactly one read.
        @(negedge clk);
        wr = 1'b1; rd = 1'b0; r2 = 4'h7;
        step();
        @(negedge clk);
        wr = 1'b0; rd = 1'b1;
        dv_count = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (dv) dv_count++;
        end
        chk("held_rd dv_count", dv_count, 1);
        chk("held_rd dout", dout, 4'h7);
        chk("held_rd empty", empty, 1'b1);
        chk("held_rd ptr", {t2, t1, t0}, 3'b001);

        // A write while RD stays high must not trigger a read or underflow.
        @(negedge clk);
        wr = 1'b1;
        step();
        @(negedge clk);
        wr = 1'b0;
        step();
        chk("held_rd_wr empty", empty, 1'b0);
        chk("held_rd_wr ufl", ufl, 1'b0);
        chk("held_rd_wr dv", dv, 1'b0);

        // Drop and re-raise RD: the next slot (R0) is read.
        @(negedge clk);
        rd = 1'b0;
        step();
        @(negedge clk);
        rd = 1'b1; r0 = 4'h9;
        step();
        chk("reraise dv", dv, 1'b1);
        chk("reraise dout", dout, 4'h9);
        chk("reraise empty", empty, 1'b1);
        chk("reraise ptr", {t2, t1, t0}, 3'b010);
        step();
        chk("reraise dv_pulse", dv, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
